// File: rtl/uart_rx16.sv
// UART receiver with 16x oversampling, driven by a synchronized baud16 strobe.
// Start bit is verified at mid-bit, data/stop sampled every OVERSAMPLE ticks thereafter.
module uart_rx16 #(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16
) (
  input  logic                 clk_50m,
  input  logic                 rst_n,
  input  logic                 baud16_clk,
  input  logic                 rxd,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 frame_err,
  output logic                 busy
);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  localparam logic [3:0] HALF_LAST = 4'(OVERSAMPLE / 2 - 1);
  localparam logic [3:0] BIT_LAST  = 4'(OVERSAMPLE - 1);
  localparam logic [2:0] BITS_LAST = 3'(DATA_BITS - 1);

  state_t               state, state_nxt;
  logic                 baud_s1, baud_s, baud_prev;
  logic                 rxd_s1, rxd_s;
  logic                 tick;
  logic [3:0]           tick_cnt;
  logic [2:0]           bit_cnt;
  logic [DATA_BITS-1:0] shift_reg;
  logic                 armed;
  logic                 start_mid, bit_end;
  logic                 load_ok, load_err;

  always_ff @(posedge clk_50m or negedge rst_n) begin
    if (!rst_n) begin
      baud_s1   <= 1'b0;
      baud_s    <= 1'b0;
      baud_prev <= 1'b0;
      rxd_s1    <= 1'b0;
      rxd_s     <= 1'b0;
    end else begin
      baud_s1   <= baud16_clk;
      baud_s    <= baud_s1;
      baud_prev <= baud_s;
      rxd_s1    <= rxd;
      rxd_s     <= rxd_s1;
    end
  end

  assign tick      = baud_s & ~baud_prev;
  assign start_mid = tick && ((tick_cnt + 4'd1) == HALF_LAST);
  assign bit_end   = tick && (tick_cnt == BIT_LAST);

  always_ff @(posedge clk_50m or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (tick && armed && !rxd_s) state_nxt = START;
      START: if (start_mid) state_nxt = rxd_s ? IDLE : DATA;
      DATA:  if (bit_end && (bit_cnt == BITS_LAST)) state_nxt = STOP;
      STOP:  if (bit_end) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy     = (state != IDLE);
    load_ok  = (state == STOP) && bit_end && rxd_s;
    load_err = (state == STOP) && bit_end && !rxd_s;
  end

  always_ff @(posedge clk_50m or negedge rst_n) begin
    if (!rst_n) begin
      tick_cnt  <= '0;
      bit_cnt   <= '0;
      shift_reg <= '0;
      armed     <= 1'b0;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      rx_valid  <= load_ok;
      frame_err <= load_err;
      case (state)
        IDLE: begin
          tick_cnt <= '0;
          if (tick && rxd_s) armed <= 1'b1;
        end
        START: begin
          if (start_mid) begin
            tick_cnt <= '0;
            bit_cnt  <= '0;
          end else if (tick) begin
            tick_cnt <= tick_cnt + 4'd1;
          end
        end
        DATA: begin
          if (tick) tick_cnt <= (tick_cnt == BIT_LAST) ? '0 : tick_cnt + 4'd1;
          if (bit_end) begin
            shift_reg <= {rxd_s, shift_reg[DATA_BITS-1:1]};
            bit_cnt   <= bit_cnt + 3'd1;
          end
        end
        STOP: begin
          if (tick) tick_cnt <= (tick_cnt == BIT_LAST) ? '0 : tick_cnt + 4'd1;
          if (load_ok)  rx_data <= shift_reg;
          // A low stop bit disarms so a held-low line cannot retrigger a start.
          if (load_err) armed <= 1'b0;
        end
        default: tick_cnt <= '0;
      endcase
    end
  end

endmodule
